// File: rtl/rs_driver.sv
// Command sequencer for a downstream RS trigger: turns a level request into a timed
// set or reset strobe followed by an idle gap, and keeps a model of the trigger state.
module rs_driver #(
   parameter int unsigned PULSE_W = 2,
   parameter int unsigned GAP_W   = 1
) (
   input  logic c_i,
   input  logic rst_i,
   input  logic req_i,
   input  logic d_i,
   output logic s_o,
   output logic r_o,
   output logic q_track_o,
   output logic busy_o,
   output logic done_o,
   output logic drop_o
);

   typedef enum logic [1:0] {
      StIdle,
      StPulse,
      StGap
   } state_e;

   localparam logic [3:0] PulseLd = 4'(PULSE_W);
   localparam logic [3:0] GapLd   = 4'(GAP_W);
   localparam bit         HasGap  = (GAP_W != 0);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       lat_q, lat_d;
   logic       s_q, s_d;
   logic       r_q, r_d;
   logic       q_q, q_d;
   logic       done_q, done_d;
   logic       drop_q, drop_d;

   always_ff @(posedge c_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         lat_q   <= 1'b0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         q_q     <= 1'b0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         s_q     <= s_d;
         r_q     <= r_d;
         q_q     <= q_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
      end
   end

   // Strobes are computed one cycle ahead so that s/r are registered outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      s_d     = 1'b0;
      r_d     = 1'b0;
      q_d     = q_q;
      done_d  = 1'b0;
      drop_d  = drop_q;

      unique case (state_q)
         StIdle: begin
            if (req_i) begin
               if (d_i != q_q) begin
                  state_d = StPulse;
                  cnt_d   = PulseLd;
                  lat_d   = d_i;
                  s_d     = d_i;
                  r_d     = ~d_i;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         StPulse: begin
            if (req_i) begin
               drop_d = 1'b1;
            end
            if (cnt_q <= 4'd1) begin
               q_d = lat_q;
               if (HasGap) begin
                  state_d = StGap;
                  cnt_d   = GapLd;
               end else begin
                  state_d = StIdle;
                  cnt_d   = 4'd0;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
               s_d   = lat_q;
               r_d   = ~lat_q;
            end
         end

         StGap: begin
            if (req_i) begin
               drop_d = 1'b1;
            end
            if (cnt_q <= 4'd1) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         default: begin
            state_d = StIdle;
            cnt_d   = 4'd0;
         end
      endcase
   end

   assign s_o       = s_q;
   assign r_o       = r_q;
   assign q_track_o = q_q;
   assign busy_o    = (state_q != StIdle);
   assign done_o    = done_q;
   assign drop_o    = drop_q;

endmodule

// File: tb/tb_rs_driver.sv
// Bench for rs_driver: directed vector table, alternating-command sequence on a
// PULSE_W=1/GAP_W=0 instance, and random traffic against a timeline reference model.
module tb_rs_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0 = 1'b1, req0 = 1'b0, d0 = 1'b0;
   logic s0, r0, q0, busy0, done0, drop0;
   logic rst1 = 1'b1, req1 = 1'b0, d1 = 1'b0;
   logic s1, r1, q1, busy1, done1, drop1;

   rs_driver #(.PULSE_W(2), .GAP_W(1)) u_dut0 (
      .c_i(clk), .rst_i(rst0), .req_i(req0), .d_i(d0),
      .s_o(s0), .r_o(r0), .q_track_o(q0), .busy_o(busy0), .done_o(done0), .drop_o(drop0)
   );

   rs_driver #(.PULSE_W(1), .GAP_W(0)) u_dut1 (
      .c_i(clk), .rst_i(rst1), .req_i(req1), .d_i(d1),
      .s_o(s1), .r_o(r1), .q_track_o(q1), .busy_o(busy1), .done_o(done1), .drop_o(drop1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic cmp(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Reference model: each accepted command at cycle t owns a fixed timeline
   // (strobe t+1..t+P, busy t+1..t+P+G, new level from t+P+1, done at t+P+G+1).
   int m_p[2] = '{2, 1};
   int m_g[2] = '{1, 0};
   int m_cyc[2], m_tacc[2], m_done_at[2];
   bit m_act[2], m_lat[2], m_qb[2], m_drop[2];

   function automatic bit m_busy(input int k);
      return m_act[k] && m_cyc[k] >= m_tacc[k] + 1 && m_cyc[k] <= m_tacc[k] + m_p[k] + m_g[k];
   endfunction

   function automatic bit m_strobe(input int k);
      return m_act[k] && m_cyc[k] >= m_tacc[k] + 1 && m_cyc[k] <= m_tacc[k] + m_p[k];
   endfunction

   function automatic bit m_q(input int k);
      return (m_act[k] && m_cyc[k] >= m_tacc[k] + m_p[k] + 1) ? m_lat[k] : m_qb[k];
   endfunction

   task automatic m_edge(input int k, input bit rs, input bit rq, input bit dd);
      bit idle, qn;
      if (rs) begin
         m_act[k] = 1'b0; m_qb[k] = 1'b0; m_drop[k] = 1'b0; m_done_at[k] = -1;
      end else begin
         idle = !m_busy(k);
         qn   = m_q(k);
         if (m_act[k] && m_cyc[k] == m_tacc[k] + m_p[k] + m_g[k]) begin
            m_qb[k] = m_lat[k]; m_act[k] = 1'b0; m_done_at[k] = m_cyc[k] + 1;
         end
         if (rq) begin
            if (!idle) m_drop[k] = 1'b1;
            else if (dd != qn) begin
               m_act[k] = 1'b1; m_tacc[k] = m_cyc[k]; m_lat[k] = dd;
            end else m_done_at[k] = m_cyc[k] + 1;
         end
      end
      m_cyc[k]++;
   endtask

   task automatic run_random(input int k, input int n);
      logic as, ar, aq, ab, adn, adr;
      bit rs, rq, dd, st;
      m_cyc[k] = 0; m_act[k] = 1'b0; m_qb[k] = 1'b0; m_drop[k] = 1'b0; m_done_at[k] = -1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (k == 0) begin as = s0; ar = r0; aq = q0; ab = busy0; adn = done0; adr = drop0; end
         else begin as = s1; ar = r1; aq = q1; ab = busy1; adn = done1; adr = drop1; end
         if (i > 0) begin
            st = m_strobe(k);
            cmp($sformatf("rnd%0d[%0d] s", k, i), as, st && m_lat[k]);
            cmp($sformatf("rnd%0d[%0d] r", k, i), ar, st && !m_lat[k]);
            cmp($sformatf("rnd%0d[%0d] q_track", k, i), aq, m_q(k));
            cmp($sformatf("rnd%0d[%0d] busy", k, i), ab, m_busy(k));
            cmp($sformatf("rnd%0d[%0d] done", k, i), adn, m_cyc[k] == m_done_at[k]);
            cmp($sformatf("rnd%0d[%0d] drop", k, i), adr, m_drop[k]);
            cmp($sformatf("rnd%0d[%0d] s&r", k, i), as & ar, 1'b0);
         end
         rs = (i == 0) || ($urandom_range(0, 39) == 0);
         rq = ($urandom_range(0, 2) == 0);
         dd = 1'($urandom_range(0, 1));
         if (k == 0) begin rst0 = rs; req0 = rq; d0 = dd; end
         else begin rst1 = rs; req1 = rq; d1 = dd; end
         m_edge(k, rs, rq, dd);
      end
   endtask

   typedef struct {
      bit rst, req, d;
      bit s, r, q, busy, done, drop;
      bit chk;
   } vec_t;

   vec_t tbl[29];

   initial begin
      tbl[0]  = '{1,1,1, 0,0,0,0,0,0, 0};
      tbl[1]  = '{0,0,0, 0,0,0,0,0,0, 1};
      tbl[2]  = '{0,1,1, 0,0,0,0,0,0, 1};
      tbl[3]  = '{0,0,0, 1,0,0,1,0,0, 1};
      tbl[4]  = '{0,0,0, 1,0,0,1,0,0, 1};
      tbl[5]  = '{0,0,0, 0,0,1,1,0,0, 1};
      tbl[6]  = '{0,0,0, 0,0,1,0,1,0, 1};
      tbl[7]  = '{0,1,1, 0,0,1,0,0,0, 1};
      tbl[8]  = '{0,0,0, 0,0,1,0,1,0, 1};
      tbl[9]  = '{0,0,0, 0,0,1,0,0,0, 1};
      tbl[10] = '{0,1,0, 0,0,1,0,0,0, 1};
      tbl[11] = '{0,0,0, 0,1,1,1,0,0, 1};
      tbl[12] = '{0,0,0, 0,1,1,1,0,0, 1};
      tbl[13] = '{0,0,0, 0,0,0,1,0,0, 1};
      tbl[14] = '{0,1,1, 0,0,0,0,1,0, 1};
      tbl[15] = '{0,0,0, 1,0,0,1,0,0, 1};
      tbl[16] = '{0,1,0, 1,0,0,1,0,0, 1};
      tbl[17] = '{0,0,0, 0,0,1,1,0,1, 1};
      tbl[18] = '{0,1,0, 0,0,1,0,1,1, 1};
      tbl[19] = '{0,0,0, 0,1,1,1,0,1, 1};
      tbl[20] = '{0,0,0, 0,1,1,1,0,1, 1};
      tbl[21] = '{0,0,0, 0,0,0,1,0,1, 1};
      tbl[22] = '{0,0,0, 0,0,0,0,1,1, 1};
      tbl[23] = '{1,0,0, 0,0,0,0,0,1, 1};
      tbl[24] = '{0,1,1, 0,0,0,0,0,0, 1};
      tbl[25] = '{0,1,0, 1,0,0,1,0,0, 1};
      tbl[26] = '{1,0,0, 1,0,0,1,0,1, 1};
      tbl[27] = '{0,0,0, 0,0,0,0,0,0, 1};
      tbl[28] = '{0,0,0, 0,0,0,0,0,0, 1};

      for (int i = 0; i < 29; i++) begin
         @(negedge clk);
         if (tbl[i].chk) begin
            cmp($sformatf("tbl[%0d] s", i), s0, tbl[i].s);
            cmp($sformatf("tbl[%0d] r", i), r0, tbl[i].r);
            cmp($sformatf("tbl[%0d] q_track", i), q0, tbl[i].q);
            cmp($sformatf("tbl[%0d] busy", i), busy0, tbl[i].busy);
            cmp($sformatf("tbl[%0d] done", i), done0, tbl[i].done);
            cmp($sformatf("tbl[%0d] drop", i), drop0, tbl[i].drop);
         end
         rst0 = tbl[i].rst; req0 = tbl[i].req; d0 = tbl[i].d;
      end
      @(negedge clk);
      req0 = 1'b0;

      // Alternating commands, each issued in the previous command's done cycle.
      for (int i = 0; i < 8; i++) begin
         bit v;
         v = (i % 2 == 0);
         @(negedge clk);
         cmp($sformatf("alt[%0d] idle busy", i), busy1, 1'b0);
         cmp($sformatf("alt[%0d] done", i), done1, i > 0);
         cmp($sformatf("alt[%0d] q_track", i), q1, !v);
         rst1 = 1'b0; req1 = 1'b1; d1 = v;
         @(negedge clk);
         cmp($sformatf("alt[%0d] s", i), s1, v);
         cmp($sformatf("alt[%0d] r", i), r1, !v);
         cmp($sformatf("alt[%0d] busy", i), busy1, 1'b1);
         cmp($sformatf("alt[%0d] s&r", i), s1 & r1, 1'b0);
         req1 = 1'b0;
      end
      @(negedge clk);
      cmp("alt end done", done1, 1'b1);
      cmp("alt end q_track", q1, 1'b0);
      cmp("alt end drop", drop1, 1'b0);

      run_random(0, 400);
      run_random(1, 300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected completion");
      $fatal(1, "timeout");
   end

endmodule
